// File: rtl/mac_vec_multi_if.sv
// mac_vec_multi_if: register bus of the multi-lane MAC (operands, control, result and status)
interface mac_vec_multi_if #(parameter int DATA_W = 8, LANES = 4, ACC_W = 16);
  logic [LANES*DATA_W-1:0] MAC_INA;
  logic [LANES*DATA_W-1:0] MAC_INB;
  logic [7:0] MAC_CTRL;
  logic [ACC_W-1:0] MAC_OUT;
  logic IRQ_MAC;
  logic MAC_BUSY;
  logic MAC_OVF;
  modport master (output MAC_INA, MAC_INB, MAC_CTRL, input MAC_OUT, IRQ_MAC, MAC_BUSY, MAC_OVF);
  modport slave (input MAC_INA, MAC_INB, MAC_CTRL, output MAC_OUT, IRQ_MAC, MAC_BUSY, MAC_OVF);
endinterface

// File: rtl/mac_vec_multi.sv
// mac_vec_multi: serial multi-lane MUL/MAC/DOT/DOTACC engine; define MAC_SAT_EN to honour CTRL[5] saturation
module mac_vec_multi #(parameter int DATA_W = 8, LANES = 4, ACC_W = 16) (
  input logic clk,
  input logic reset,
  mac_vec_multi_if.slave bus
);
  localparam int W = ACC_W + $clog2(LANES) + 1;
  localparam int RW = W + 1;
  localparam int P = 2 * DATA_W;
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_n;
  logic start_q, sgn, irq_en, clr, en, start_ev, last, ovf, ok;
`ifdef MAC_SAT_EN
  logic sat;
`endif
  logic [1:0] mode;
  logic [LANES*DATA_W-1:0] a, b;
  logic [W-1:0] wrk, wrk_n;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] a_l, b_l;
  logic [P-1:0] prod;
  logic [RW-1:0] base, r;
  logic [ACC_W-1:0] res;
  assign en = bus.MAC_CTRL[7];
  assign start_ev = en & bus.MAC_CTRL[1] & ~start_q;
  assign bus.MAC_BUSY = state == MUL;
  assign a_l = a[idx*DATA_W +: DATA_W];
  assign b_l = b[idx*DATA_W +: DATA_W];
  assign prod = {{DATA_W{sgn & a_l[DATA_W-1]}}, a_l} * {{DATA_W{sgn & b_l[DATA_W-1]}}, b_l};
  assign wrk_n = wrk + {{(W-P){sgn & prod[P-1]}}, prod};
  assign last = mode[1] ? idx == IW'(LANES - 1) : 1'b1;
  assign base = (clr | ~mode[0]) ? '0 : {{(RW-ACC_W){sgn & bus.MAC_OUT[ACC_W-1]}}, bus.MAC_OUT};
  assign r = {sgn & wrk_n[W-1], wrk_n} + base;
  // Signed fits when every bit from the ACC_W sign bit upward agrees; unsigned when the upper bits are zero
  assign ok = sgn ? (&r[RW-1:ACC_W-1] | ~|r[RW-1:ACC_W-1]) : ~|r[RW-1:ACC_W];
  assign ovf = ~ok;
`ifdef MAC_SAT_EN
  assign res = (sat & ovf) ? (r[RW-1] ? {sgn, {(ACC_W-1){1'b0}}} : {~sgn, {(ACC_W-1){1'b1}}}) : r[ACC_W-1:0];
`else
  assign res = r[ACC_W-1:0];
`endif
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start_ev ? MUL : IDLE;
    else if (state == MUL) state_n = !en ? IDLE : last ? DONE : MUL;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      start_q <= 1'b0;
      bus.MAC_OUT <= '0;
      bus.IRQ_MAC <= 1'b0;
      bus.MAC_OVF <= 1'b0;
      a <= '0;
      b <= '0;
      sgn <= 1'b0;
      irq_en <= 1'b0;
      clr <= 1'b0;
      mode <= '0;
      wrk <= '0;
      idx <= '0;
`ifdef MAC_SAT_EN
      sat <= 1'b0;
`endif
    end else begin
      state <= state_n;
      start_q <= bus.MAC_CTRL[1];
      if (!en) bus.IRQ_MAC <= 1'b0;
      if (state == IDLE && start_ev) begin
        a <= bus.MAC_INA;
        b <= bus.MAC_INB;
        sgn <= bus.MAC_CTRL[6];
        clr <= bus.MAC_CTRL[4];
        mode <= bus.MAC_CTRL[3:2];
        irq_en <= bus.MAC_CTRL[0];
`ifdef MAC_SAT_EN
        sat <= bus.MAC_CTRL[5];
`endif
        wrk <= '0;
        idx <= '0;
        bus.IRQ_MAC <= 1'b0;
        if (bus.MAC_CTRL[4]) bus.MAC_OVF <= 1'b0;
      end
      if (state == MUL && en) begin
        wrk <= wrk_n;
        idx <= idx + 1'b1;
        if (last) begin
          bus.MAC_OUT <= res;
          if (ovf) bus.MAC_OVF <= 1'b1;
        end
      end
      if (state == DONE && en) bus.IRQ_MAC <= irq_en;
    end
  end
endmodule
